// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants, transmitter state type and the byte-wise CRC-32 step.
package eth_pkg;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IP  = 16'h0800;
  localparam logic [7:0]  ARP_HLEN      = 8'h06;
  localparam logic [7:0]  ARP_PLEN      = 8'h04;
  localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
  localparam logic [15:0] ARP_OP_RPLY   = 16'h0002;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [5:0]  HDR_LAST      = 6'd41;
  localparam logic [5:0]  PAD_LAST      = 6'd17;
  localparam logic [5:0]  FCS_LAST      = 6'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_HDR      = 3'd3,
    ST_PAD      = 3'd4,
    ST_FCS      = 3'd5,
    ST_IFG      = 3'd6
  } tx_state_e;

  // Reflected CRC-32, data bits consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-parallel CRC-32 accumulator: clear to the init value, absorb one byte per enabled cycle.
module crc32_d8 import eth_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;

  // CRC register: clear has priority over enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_crc <= CRC32_INIT;
    end else if (i_clr) begin
      r_crc <= CRC32_INIT;
    end else if (i_en) begin
      r_crc <= crc32_byte(r_crc, i_data);
    end else begin
      r_crc <= r_crc;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/arp_frame_tx.sv
// ARP request/reply frame transmitter: queues one request and one reply, serialises
// preamble, SFD, header, pad and FCS as bytes or nibbles, then holds off for the IFG.
module arp_frame_tx import eth_pkg::*; #(
  parameter int DATA_W       = 8,
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_LEN      = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [47:0]       local_mac,
  input  logic [31:0]       local_ip,
  input  logic              req_start,
  input  logic [31:0]       req_ip,
  input  logic              rply_start,
  input  logic [47:0]       rply_mac,
  input  logic [31:0]       rply_ip,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              tx_done,
  output logic              tx_busy,
  output logic [15:0]       frame_cnt
);

  localparam bit        NIBBLE   = (DATA_W == 4);
  localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_LEN - 1);
  localparam logic [5:0] IFG_LAST = (IFG_LEN == 0) ? 6'd0 : 6'(IFG_LEN - 1);

  logic        r_req_pend, r_rply_pend;
  logic [31:0] r_req_ip, r_rply_ip;
  logic [47:0] r_rply_mac;

  tx_state_e   r_state;
  logic [5:0]  r_cnt;
  logic        r_phase;
  logic        r_is_rply;
  logic [47:0] r_src_mac, r_tgt_mac;
  logic [31:0] r_src_ip, r_tgt_ip;

  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_valid, r_tx_done, r_tx_busy;
  logic [15:0]       r_frame_cnt;

  logic        w_byte_end, w_cnt_last, w_state_done, w_launch, w_valid_st, w_frame_end, w_crc_en;
  tx_state_e   w_next_state;
  logic [335:0] w_hdr;
  logic [8:0]  w_hdr_lsb;
  logic [31:0] w_crc, w_fcs;
  logic [7:0]  w_byte, w_shift;

  // Byte sequencing, next-state and launch decisions.
  always_comb begin
    w_byte_end = NIBBLE ? r_phase : 1'b1;
    w_cnt_last = 1'b0;
    w_next_state = ST_IDLE;
    case (r_state)
      ST_PREAMBLE: begin w_cnt_last = (r_cnt == PRE_LAST); w_next_state = ST_SFD; end
      ST_SFD:      begin w_cnt_last = 1'b1;                 w_next_state = ST_HDR; end
      ST_HDR:      begin w_cnt_last = (r_cnt == HDR_LAST);  w_next_state = ST_PAD; end
      ST_PAD:      begin w_cnt_last = (r_cnt == PAD_LAST);  w_next_state = ST_FCS; end
      ST_FCS:      begin w_cnt_last = (r_cnt == FCS_LAST);
                         w_next_state = (IFG_LEN == 0) ? ST_IDLE : ST_IFG; end
      ST_IFG:      begin w_cnt_last = (r_cnt == IFG_LAST);  w_next_state = ST_IDLE; end
      default:     begin w_cnt_last = 1'b0;                 w_next_state = ST_IDLE; end
    endcase
    w_state_done = w_byte_end && w_cnt_last;
    w_frame_end  = (r_state == ST_FCS) && w_state_done;
    // A queued frame may follow the gap directly so the idle time is exactly IFG_LEN.
    w_launch = (r_req_pend || r_rply_pend) &&
               ((r_state == ST_IDLE) ||
                (w_state_done && ((r_state == ST_IFG) || ((r_state == ST_FCS) && (IFG_LEN == 0)))));
    w_valid_st = (r_state == ST_PREAMBLE) || (r_state == ST_SFD) || (r_state == ST_HDR) ||
                 (r_state == ST_PAD) || (r_state == ST_FCS);
    w_crc_en = w_byte_end && ((r_state == ST_HDR) || (r_state == ST_PAD));
  end

  // Header byte mux and beat selection.
  always_comb begin
    w_hdr = {(r_is_rply ? r_tgt_mac : 48'hFFFF_FFFF_FFFF), r_src_mac, ETH_TYPE_ARP,
             ARP_HTYPE_ETH, ARP_PTYPE_IP, ARP_HLEN, ARP_PLEN,
             (r_is_rply ? ARP_OP_RPLY : ARP_OP_REQ), r_src_mac, r_src_ip, r_tgt_mac, r_tgt_ip};
    w_hdr_lsb = {(HDR_LAST - r_cnt), 3'b000};
    w_fcs = ~w_crc;
    case (r_state)
      ST_PREAMBLE: w_byte = PREAMBLE_BYTE;
      ST_SFD:      w_byte = SFD_BYTE;
      ST_HDR:      w_byte = w_hdr[w_hdr_lsb +: 8];
      ST_FCS:      w_byte = w_fcs[{r_cnt[1:0], 3'b000} +: 8];
      default:     w_byte = 8'h00;
    endcase
    if (NIBBLE && r_phase) begin
      w_shift = {4'h0, w_byte[7:4]};
    end else begin
      w_shift = w_byte;
    end
  end

  crc32_d8 u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_launch),
    .i_en   (w_crc_en),
    .i_data (w_byte),
    .o_crc  (w_crc)
  );

  // Pending flags and latched start fields; a new pulse outranks the clear on launch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_pend  <= 1'b0;
      r_rply_pend <= 1'b0;
      r_req_ip    <= 32'h0;
      r_rply_mac  <= 48'h0;
      r_rply_ip   <= 32'h0;
    end else begin
      if (req_start) begin
        r_req_pend <= 1'b1;
        r_req_ip   <= req_ip;
      end else if (w_launch && !r_rply_pend) begin
        r_req_pend <= 1'b0;
      end else begin
        r_req_pend <= r_req_pend;
      end
      if (rply_start) begin
        r_rply_pend <= 1'b1;
        r_rply_mac  <= rply_mac;
        r_rply_ip   <= rply_ip;
      end else if (w_launch) begin
        r_rply_pend <= 1'b0;
      end else begin
        r_rply_pend <= r_rply_pend;
      end
    end
  end

  // Frame FSM with one-cycle registered output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 6'd0;
      r_phase     <= 1'b0;
      r_is_rply   <= 1'b0;
      r_src_mac   <= 48'h0;
      r_src_ip    <= 32'h0;
      r_tgt_mac   <= 48'h0;
      r_tgt_ip    <= 32'h0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_done   <= 1'b0;
      r_tx_busy   <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      if (w_launch) begin
        r_state   <= ST_PREAMBLE;
        r_cnt     <= 6'd0;
        r_phase   <= 1'b0;
        r_is_rply <= r_rply_pend;
        r_src_mac <= local_mac;
        r_src_ip  <= local_ip;
        r_tgt_mac <= r_rply_pend ? r_rply_mac : 48'h0;
        r_tgt_ip  <= r_rply_pend ? r_rply_ip : r_req_ip;
      end else if (r_state != ST_IDLE) begin
        if (!w_byte_end) begin
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          if (w_cnt_last) begin
            r_cnt   <= 6'd0;
            r_state <= w_next_state;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
      end else begin
        r_phase <= 1'b0;
      end
      r_tx_valid <= w_valid_st;
      r_tx_data  <= w_valid_st ? w_shift[DATA_W-1:0] : '0;
      r_tx_busy  <= (r_state != ST_IDLE);
      r_tx_done  <= w_frame_end;
      if (w_frame_end) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else begin
        r_frame_cnt <= r_frame_cnt;
      end
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign tx_done   = r_tx_done;
  assign tx_busy   = r_tx_busy;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_arp_frame_tx.sv
// Scoreboard bench for arp_frame_tx: a byte-wide and a nibble-wide instance, expected
// beats queued at stimulus time and checked by per-instance monitors as they appear.
module tb_arp_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] local_mac = 48'h112233445566;
  logic [31:0] local_ip = 32'hC0A80008;
  logic        req_start = 1'b0, req_start4 = 1'b0, rply_start = 1'b0;
  logic [31:0] req_ip = 32'h0, rply_ip = 32'h0;
  logic [47:0] rply_mac = 48'h0;

  logic [7:0]  tx_data8;
  logic [3:0]  tx_data4;
  logic        tx_valid8, tx_done8, tx_busy8, tx_valid4, tx_done4, tx_busy4;
  logic [15:0] frame_cnt8, frame_cnt4;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  logic [7:0] exp8_q[$];
  logic [3:0] exp4_q[$];
  logic [7:0] rx8_q[$];
  logic [7:0] fb[72];

  int done8 = 0, done4 = 0, start8 = 0, gap8 = 0, lastv8 = -100, busy_low8 = 0;
  int gap4 = 0, lastv4 = -100, run4 = 0;
  bit vprev8 = 1'b0, vprev4 = 1'b0;

  arp_frame_tx #(.DATA_W(8), .PREAMBLE_LEN(7), .IFG_LEN(12)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .local_mac(local_mac), .local_ip(local_ip),
    .req_start(req_start), .req_ip(req_ip), .rply_start(rply_start),
    .rply_mac(rply_mac), .rply_ip(rply_ip), .tx_data(tx_data8), .tx_valid(tx_valid8),
    .tx_done(tx_done8), .tx_busy(tx_busy8), .frame_cnt(frame_cnt8));

  arp_frame_tx #(.DATA_W(4), .PREAMBLE_LEN(7), .IFG_LEN(12)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .local_mac(local_mac), .local_ip(local_ip),
    .req_start(req_start4), .req_ip(req_ip), .rply_start(1'b0),
    .rply_mac(rply_mac), .rply_ip(rply_ip), .tx_data(tx_data4), .tx_valid(tx_valid4),
    .tx_done(tx_done4), .tx_busy(tx_busy4), .frame_cnt(frame_cnt4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Byte-wide monitor: pops the scoreboard on every valid beat.
  always @(negedge clk) begin
    logic [7:0] e;
    if (mon_en) begin
      if (tx_valid8) begin
        if (!vprev8) begin
          start8 = cyc;
          gap8 = cyc - lastv8 - 1;
          rx8_q.delete();
        end
        rx8_q.push_back(tx_data8);
        lastv8 = cyc;
        n_cmp++;
        if (exp8_q.size() == 0) begin
          n_err++;
          $display("FAIL beat8 unexpected: got %h, expected no beat", tx_data8);
        end else begin
          e = exp8_q.pop_front();
          if (tx_data8 !== e) begin
            n_err++;
            $display("FAIL beat8 #%0d: got %h, expected %h", rx8_q.size() - 1, tx_data8, e);
          end
        end
      end else begin
        n_cmp++;
        if (tx_data8 !== 8'h00) begin
          n_err++;
          $display("FAIL idle8 data: got %h, expected 00", tx_data8);
        end
      end
      if (tx_done8) done8++;
      if (!tx_busy8) busy_low8++;
      vprev8 = tx_valid8;
    end
  end

  // Nibble-wide monitor.
  always @(negedge clk) begin
    logic [3:0] e;
    if (mon_en) begin
      if (tx_valid4) begin
        if (!vprev4) begin
          gap4 = cyc - lastv4 - 1;
          run4 = 0;
        end
        run4++;
        lastv4 = cyc;
        n_cmp++;
        if (exp4_q.size() == 0) begin
          n_err++;
          $display("FAIL beat4 unexpected: got %h, expected no beat", tx_data4);
        end else begin
          e = exp4_q.pop_front();
          if (tx_data4 !== e) begin
            n_err++;
            $display("FAIL beat4 #%0d: got %h, expected %h", run4 - 1, tx_data4, e);
          end
        end
      end
      if (tx_done4) done4++;
      vprev4 = tx_valid4;
    end
  end

  task automatic make_frame(input bit rply, input logic [47:0] tmac, input logic [31:0] tip);
    logic [335:0] hdr;
    logic [31:0]  crc;
    hdr = {(rply ? tmac : 48'hFFFFFFFFFFFF), local_mac, 16'h0806, 16'h0001, 16'h0800,
           8'h06, 8'h04, (rply ? 16'h0002 : 16'h0001), local_mac, local_ip,
           (rply ? tmac : 48'h0), tip};
    for (int i = 0; i < 7; i++) fb[i] = 8'h55;
    fb[7] = 8'hD5;
    for (int i = 0; i < 42; i++) fb[8 + i] = hdr[335 - 8 * i -: 8];
    for (int i = 50; i < 68; i++) fb[i] = 8'h00;
    crc = 32'hFFFFFFFF;
    for (int i = 8; i < 68; i++) crc = crc_upd(crc, fb[i]);
    crc = ~crc;
    for (int i = 0; i < 4; i++) fb[68 + i] = crc[8 * i +: 8];
  endtask

  task automatic push8();
    for (int i = 0; i < 72; i++) exp8_q.push_back(fb[i]);
  endtask

  task automatic push4();
    for (int i = 0; i < 72; i++) begin
      exp4_q.push_back(fb[i][3:0]);
      exp4_q.push_back(fb[i][7:4]);
    end
  endtask

  task automatic pulse(input bit r8, input bit r4, input bit p8, input logic [31:0] rip,
                       input logic [47:0] pmac, input logic [31:0] pip, output int samp);
    @(posedge clk); #1;
    req_start = r8; req_start4 = r4; rply_start = p8;
    req_ip = rip; rply_mac = pmac; rply_ip = pip;
    @(posedge clk); #1;
    samp = cyc;
    req_start = 1'b0; req_start4 = 1'b0; rply_start = 1'b0;
  endtask

  task automatic wait_done8(input int target, input int budget, output bit ok);
    for (int k = 0; k < budget && done8 < target; k++) begin @(negedge clk); #1; end
    ok = (done8 >= target);
  endtask

  task automatic wait_idle8(input int budget, output bit ok);
    for (int k = 0; k < budget && (tx_busy8 || exp8_q.size() != 0); k++) begin @(negedge clk); #1; end
    ok = !tx_busy8;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++; if (tx_valid8 !== 1'b0 || tx_data8 !== 8'h00) begin n_err++; $display("FAIL reset_valid8: got %b/%h, expected 0/00", tx_valid8, tx_data8); end
    n_cmp++; if (tx_done8 !== 1'b0 || tx_busy8 !== 1'b0) begin n_err++; $display("FAIL reset_done_busy8: got %b/%b, expected 0/0", tx_done8, tx_busy8); end
    n_cmp++; if (frame_cnt8 !== 16'd0) begin n_err++; $display("FAIL reset_cnt8: got %h, expected 0000", frame_cnt8); end
    n_cmp++; if (tx_valid4 !== 1'b0 || tx_data4 !== 4'h0 || tx_busy4 !== 1'b0 || frame_cnt4 !== 16'd0) begin
      n_err++; $display("FAIL reset_dut4: got %b/%h/%b/%h, expected all zero", tx_valid4, tx_data4, tx_busy4, frame_cnt4); end
    mon_en = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (4) @(negedge clk); #1;
    n_cmp++; if (tx_busy8 !== 1'b0 || tx_valid8 !== 1'b0) begin n_err++; $display("FAIL idle_after_reset: got busy %b valid %b, expected 0 0", tx_busy8, tx_valid8); end
  endtask

  task automatic test_reset_mid_frame();
    int s, d0;
    bit ok;
    make_frame(1'b0, 48'h0, 32'hC0A80009); push8();
    pulse(1'b1, 1'b0, 1'b0, 32'hC0A80009, 48'h0, 32'h0, s);
    for (int k = 0; k < 200 && !(tx_valid8 && rx8_q.size() == 29); k++) begin @(negedge clk); #1; end
    n_cmp++; if (rx8_q.size() != 29) begin n_err++; $display("FAIL rst_reach_hdr20: got %0d beats, expected 29", rx8_q.size()); end
    d0 = done8;
    rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); #1;
    exp8_q.delete();
    n_cmp++; if (tx_valid8 !== 1'b0) begin n_err++; $display("FAIL rst_abort_valid: got %b, expected 0", tx_valid8); end
    n_cmp++; if (frame_cnt8 !== 16'd0) begin n_err++; $display("FAIL rst_abort_cnt: got %h, expected 0000", frame_cnt8); end
    repeat (100) @(negedge clk); #1;
    n_cmp++; if (done8 != d0) begin n_err++; $display("FAIL rst_no_done: got %0d dones, expected %0d", done8, d0); end
    make_frame(1'b0, 48'h0, 32'hC0A8000A); push8();
    pulse(1'b1, 1'b0, 1'b0, 32'hC0A8000A, 48'h0, 32'h0, s);
    wait_done8(d0 + 1, 300, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_refire_timeout: got %0d dones, expected %0d", done8, d0 + 1); end
    n_cmp++; if (frame_cnt8 !== 16'd1) begin n_err++; $display("FAIL rst_refire_cnt: got %h, expected 0001", frame_cnt8); end
    wait_idle8(200, ok);
  endtask

  task automatic test_request();
    int s, d0;
    logic [15:0] f0;
    logic [31:0] crc, rev;
    bit ok;
    d0 = done8; f0 = frame_cnt8;
    make_frame(1'b0, 48'h0, 32'hC0A80002); push8();
    pulse(1'b1, 1'b0, 1'b0, 32'hC0A80002, 48'h0, 32'h0, s);
    wait_done8(d0 + 1, 300, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL req_timeout: got %0d dones, expected %0d", done8, d0 + 1); end
    n_cmp++; if (start8 - s != 2) begin n_err++; $display("FAIL req_latency: got %0d cycles, expected 2", start8 - s); end
    n_cmp++; if (frame_cnt8 !== f0 + 16'd1) begin n_err++; $display("FAIL req_cnt: got %h, expected %h", frame_cnt8, f0 + 16'd1); end
    n_cmp++;
    if (rx8_q.size() != 72) begin
      n_err++; $display("FAIL req_len: got %0d beats, expected 72", rx8_q.size());
    end else begin
      crc = 32'hFFFFFFFF;
      for (int i = 8; i < 72; i++) crc = crc_upd(crc, rx8_q[i]);
      for (int i = 0; i < 32; i++) rev[i] = crc[31 - i];
      n_cmp++; if (rev !== 32'hC704DD7B) begin n_err++; $display("FAIL req_residue: got %h, expected c704dd7b", rev); end
    end
    wait_idle8(200, ok);
  endtask

  task automatic test_reply();
    int s, d0;
    logic [15:0] f0;
    bit ok;
    d0 = done8; f0 = frame_cnt8;
    make_frame(1'b1, 48'h000A35010203, 32'hC0A80002); push8();
    pulse(1'b0, 1'b0, 1'b1, 32'h0, 48'h000A35010203, 32'hC0A80002, s);
    wait_done8(d0 + 1, 300, ok);
    wait_idle8(200, ok);
    n_cmp++; if (done8 != d0 + 1) begin n_err++; $display("FAIL rply_done_once: got %0d, expected %0d", done8 - d0, 1); end
    n_cmp++; if (frame_cnt8 !== f0 + 16'd1) begin n_err++; $display("FAIL rply_cnt: got %h, expected %h", frame_cnt8, f0 + 16'd1); end
  endtask

  task automatic test_back_to_back();
    int s, d0;
    bit ok;
    d0 = done8;
    make_frame(1'b1, 48'h000A35AABBCC, 32'hC0A80011); push8();
    make_frame(1'b0, 48'h0, 32'hC0A80022); push8();
    pulse(1'b1, 1'b0, 1'b1, 32'hC0A80022, 48'h000A35AABBCC, 32'hC0A80011, s);
    for (int k = 0; k < 20 && !tx_valid8; k++) begin @(negedge clk); #1; end
    busy_low8 = 0;
    wait_done8(d0 + 2, 400, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_timeout: got %0d dones, expected %0d", done8 - d0, 2); end
    n_cmp++; if (gap8 != 12) begin n_err++; $display("FAIL b2b_gap: got %0d clks, expected 12", gap8); end
    n_cmp++; if (busy_low8 != 0) begin n_err++; $display("FAIL b2b_busy: got %0d low clks, expected 0", busy_low8); end
    wait_idle8(200, ok);
  endtask

  task automatic test_overwrite();
    int s, d0;
    bit ok;
    d0 = done8;
    make_frame(1'b1, 48'h000A35010203, 32'hC0A80002); push8();
    pulse(1'b0, 1'b0, 1'b1, 32'h0, 48'h000A35010203, 32'hC0A80002, s);
    for (int k = 0; k < 20 && !tx_valid8; k++) begin @(negedge clk); #1; end
    pulse(1'b1, 1'b0, 1'b0, 32'hC0A800AA, 48'h0, 32'h0, s);
    repeat (5) @(posedge clk);
    make_frame(1'b0, 48'h0, 32'hC0A800BB); push8();
    pulse(1'b1, 1'b0, 1'b0, 32'hC0A800BB, 48'h0, 32'h0, s);
    wait_done8(d0 + 2, 400, ok);
    repeat (200) @(negedge clk); #1;
    n_cmp++; if (done8 != d0 + 2) begin n_err++; $display("FAIL ovw_frames: got %0d, expected 2", done8 - d0); end
    n_cmp++; if (exp8_q.size() != 0) begin n_err++; $display("FAIL ovw_leftover: got %0d bytes, expected 0", exp8_q.size()); end
  endtask

  task automatic test_nibble();
    int s, d0;
    d0 = done4;
    make_frame(1'b0, 48'h0, 32'hC0A80031); push4();
    pulse(1'b0, 1'b1, 1'b0, 32'hC0A80031, 48'h0, 32'h0, s);
    repeat (20) @(posedge clk);
    make_frame(1'b0, 48'h0, 32'hC0A80032); push4();
    pulse(1'b0, 1'b1, 1'b0, 32'hC0A80032, 48'h0, 32'h0, s);
    for (int k = 0; k < 600 && done4 < d0 + 2; k++) begin @(negedge clk); #1; end
    n_cmp++; if (done4 != d0 + 2) begin n_err++; $display("FAIL nib_timeout: got %0d dones, expected 2", done4 - d0); end
    n_cmp++; if (run4 != 144) begin n_err++; $display("FAIL nib_len: got %0d clks, expected 144", run4); end
    n_cmp++; if (gap4 != 24) begin n_err++; $display("FAIL nib_gap: got %0d clks, expected 24", gap4); end
    n_cmp++; if (frame_cnt4 !== 16'd2) begin n_err++; $display("FAIL nib_cnt: got %h, expected 0002", frame_cnt4); end
    n_cmp++; if (exp4_q.size() != 0) begin n_err++; $display("FAIL nib_leftover: got %0d nibbles, expected 0", exp4_q.size()); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_request();
    test_reply();
    test_back_to_back();
    test_overwrite();
    test_nibble();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
